// File: rtl/join_sync.sv
// N-channel rendezvous: gathers one word per channel, then presents the joined frame on a ready/valid output.
// Define JOIN_TIMEOUT_EN to discard partial rounds left open for TIMEOUT_CYCLES cycles.

module join_sync_lane #(
  parameter int DATA_W      = 16,
  parameter int KEEP_NEWEST = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              clear_i,
  output logic              flag_o,
  output logic [DATA_W-1:0] data_o,
  output logic              overrun_o
);
  logic              flag_q, flag_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic              fresh;

  // A valid on the clearing edge opens the next round rather than counting as a repeat.
  assign fresh     = valid_i && (!flag_q || clear_i);
  assign overrun_o = valid_i && flag_q && !clear_i;

  always_comb begin
    flag_d = flag_q;
    cap_d  = cap_q;
    if (fresh) begin
      flag_d = 1'b1;
      cap_d  = data_i;
    end else begin
      if (clear_i) flag_d = 1'b0;
      if (overrun_o && (KEEP_NEWEST != 0)) cap_d = data_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      flag_q <= 1'b0;
      cap_q  <= '0;
    end else begin
      flag_q <= flag_d;
      cap_q  <= cap_d;
    end
  end

  assign flag_o = flag_q;
  assign data_o = cap_q;
endmodule

module join_sync #(
  parameter int NUM_CH         = 2,
  parameter int DATA_W         = 16,
  parameter int KEEP_NEWEST    = 1,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = 16
) (
  input  logic                     clk_pixel_in,
  input  logic                     rst_n_in,
  input  logic [NUM_CH*DATA_W-1:0] ch_data_in,
  input  logic [NUM_CH-1:0]        ch_valid_in,
  output logic [NUM_CH*DATA_W-1:0] join_data_out,
  output logic                     join_valid_out,
  input  logic                     join_ready_in,
  output logic [NUM_CH-1:0]        ch_received_out,
  output logic [CNT_W-1:0]         overrun_count_out,
  output logic                     timeout_out,
  output logic [CNT_W-1:0]         timeout_count_out
);
  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;
  localparam int IW = $clog2(NUM_CH + 1);
  localparam int SW = CNT_W + IW;

  logic [0:0]                          state_q, state_d;
  logic [NUM_CH-1:0][DATA_W-1:0]       cap;
  logic [NUM_CH-1:0][DATA_W-1:0]       join_data_q, join_data_d;
  logic [NUM_CH-1:0]                   flags, lane_ovr;
  logic [CNT_W-1:0]                    ovr_q, ovr_d;
  logic [IW-1:0]                       ovr_inc;
  logic [SW-1:0]                       ovr_sum;
  logic                                all_set, hs, load, clear, tmo_fire;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    join_sync_lane #(
      .DATA_W     (DATA_W),
      .KEEP_NEWEST(KEEP_NEWEST)
    ) u_lane (
      .clk_i    (clk_pixel_in),
      .rst_n_i  (rst_n_in),
      .valid_i  (ch_valid_in[i]),
      .data_i   (ch_data_in[i*DATA_W +: DATA_W]),
      .clear_i  (clear),
      .flag_o   (flags[i]),
      .data_o   (cap[i]),
      .overrun_o(lane_ovr[i])
    );
  end

  assign all_set = &flags;
  assign hs      = (state_q == ST_FULL) && join_ready_in;
  // Back-to-back: a complete round replaces the frame on the same handshake edge.
  assign load    = all_set && ((state_q == ST_EMPTY) || hs);
  assign clear   = load || tmo_fire;

  always_comb begin
    state_d     = state_q;
    join_data_d = join_data_q;
    if (load) begin
      state_d     = ST_FULL;
      join_data_d = cap;
    end else if (hs) begin
      state_d = ST_EMPTY;
    end
  end

  // Several channels may repeat on one edge; each repeat counts.
  always_comb begin
    ovr_inc = '0;
    for (int i = 0; i < NUM_CH; i++) ovr_inc = ovr_inc + IW'(lane_ovr[i]);
    ovr_sum = SW'(ovr_q) + SW'(ovr_inc);
    ovr_d   = (ovr_sum[SW-1:CNT_W] != '0) ? '1 : ovr_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q     <= ST_EMPTY;
      join_data_q <= '0;
      ovr_q       <= '0;
    end else begin
      state_q     <= state_d;
      join_data_q <= join_data_d;
      ovr_q       <= ovr_d;
    end
  end

`ifdef JOIN_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0]    timer_q, timer_d;
  logic             tmo_q;
  logic [CNT_W-1:0] tcnt_q, tcnt_d;
  logic             partial;

  // Only the collecting round is timed; a held frame is untouched.
  assign partial  = (|flags) && !all_set;
  assign tmo_fire = partial && (timer_q == TW'(TIMEOUT_CYCLES - 1));
  assign timer_d  = (partial && !tmo_fire) ? timer_q + 1'b1 : '0;
  assign tcnt_d   = (tmo_fire && (tcnt_q != '1)) ? tcnt_q + 1'b1 : tcnt_q;

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      timer_q <= '0;
      tmo_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      timer_q <= timer_d;
      tmo_q   <= tmo_fire;
      tcnt_q  <= tcnt_d;
    end
  end

  assign timeout_out       = tmo_q;
  assign timeout_count_out = tcnt_q;
`else
  assign tmo_fire          = 1'b0;
  assign timeout_out       = 1'b0;
  assign timeout_count_out = '0;
`endif

  assign join_data_out     = join_data_q;
  assign join_valid_out    = (state_q == ST_FULL);
  assign ch_received_out   = flags;
  assign overrun_count_out = ovr_q;
endmodule

// File: tb/tb_join_sync.sv
// Bench for join_sync: two instances (keep-newest / keep-first) on shared stimulus, checked against a round model.
module tb_join_sync;
  localparam int NCH = 2;
  localparam int TO  = 8;
`ifdef JOIN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] ch_data;
  logic [1:0]  ch_valid;
  logic        ready;

  logic [31:0] jd [2];
  logic        jv [2];
  logic [1:0]  rcv [2];
  logic [15:0] ovc [2];
  logic        tov [2];
  logic [15:0] toc [2];

  int n_chk = 0;
  int n_err = 0;

  // model state, index 0 = keep newest, 1 = keep first
  bit          m_have [2][2];
  logic [15:0] m_word [2][2];
  bit          m_ov   [2];
  logic [31:0] m_out  [2];
  int          m_ovr  [2];
  int          m_age  [2];
  bit          m_tp   [2];
  int          m_tc   [2];

  always #5 clk = ~clk;

  for (genvar k = 0; k < 2; k++) begin : g_dut
    join_sync #(
      .NUM_CH(NCH), .DATA_W(16), .KEEP_NEWEST(k == 0 ? 1 : 0),
      .TIMEOUT_CYCLES(TO), .CNT_W(16)
    ) u_dut (
      .clk_pixel_in     (clk),
      .rst_n_in         (rst_n),
      .ch_data_in       (ch_data),
      .ch_valid_in      (ch_valid),
      .join_data_out    (jd[k]),
      .join_valid_out   (jv[k]),
      .join_ready_in    (ready),
      .ch_received_out  (rcv[k]),
      .overrun_count_out(ovc[k]),
      .timeout_out      (tov[k]),
      .timeout_count_out(toc[k])
    );
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic mclear();
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NCH; c++) begin
        m_have[k][c] = 1'b0;
        m_word[k][c] = '0;
      end
      m_ov[k] = 1'b0; m_out[k] = '0; m_ovr[k] = 0;
      m_age[k] = 0; m_tp[k] = 1'b0; m_tc[k] = 0;
    end
  endtask

  // One edge of the rendezvous rules, from the pre-edge view of inputs and round state.
  task automatic mstep(input int k);
    int got;
    bit all, partial, hs, load, fire, clr;
    got = 0;
    for (int c = 0; c < NCH; c++) got += int'(m_have[k][c]);
    all     = (got == NCH);
    partial = (got > 0) && !all;
    hs      = m_ov[k] && ready;
    load    = all && (!m_ov[k] || hs);
    fire    = TO_EN && partial && (m_age[k] == TO - 1);
    if (load) begin
      m_out[k] = {m_word[k][1], m_word[k][0]};
      m_ov[k]  = 1'b1;
    end else if (hs) begin
      m_ov[k] = 1'b0;
    end
    m_age[k] = (partial && !fire) ? m_age[k] + 1 : 0;
    clr = load || fire;
    for (int c = 0; c < NCH; c++) begin
      if (ch_valid[c]) begin
        if (!m_have[k][c] || clr) begin
          m_have[k][c] = 1'b1;
          m_word[k][c] = ch_data[c*16 +: 16];
        end else begin
          if (m_ovr[k] < 65535) m_ovr[k]++;
          if (k == 0) m_word[k][c] = ch_data[c*16 +: 16];
        end
      end else if (clr) begin
        m_have[k][c] = 1'b0;
      end
    end
    m_tp[k] = fire;
    if (fire && m_tc[k] < 65535) m_tc[k]++;
  endtask

  initial begin
    mclear();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) mclear();
      else for (int k = 0; k < 2; k++) mstep(k);
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("valid%0d", k), 64'(jv[k]), 64'(m_ov[k]));
        chk($sformatf("data%0d", k), 64'(jd[k]), 64'(m_out[k]));
        chk($sformatf("flags%0d", k), 64'(rcv[k]), 64'({m_have[k][1], m_have[k][0]}));
        chk($sformatf("ovr%0d", k), 64'(ovc[k]), 64'(m_ovr[k]));
        chk($sformatf("tpulse%0d", k), 64'(tov[k]), 64'(m_tp[k]));
        chk($sformatf("tcnt%0d", k), 64'(toc[k]), 64'(m_tc[k]));
      end
    end
  end

  task automatic step(input logic [1:0] v, input logic [15:0] d0, input logic [15:0] d1, input logic rdy);
    ch_valid = v;
    ch_data  = {d1, d0};
    ready    = rdy;
    @(negedge clk);
  endtask

  task automatic idle(input logic rdy);
    step(2'b00, 16'h0, 16'h0, rdy);
  endtask

  initial begin
    rst_n = 1'b0; ch_valid = '0; ch_data = '0; ready = 1'b0;
    #1;
    chk("rst_valid", 64'(jv[0]), 64'd0);
    chk("rst_data", 64'(jd[0]), 64'd0);
    chk("rst_flags", 64'(rcv[1]), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // basic join with ready high
    step(2'b01, 16'h0012, 16'h0, 1'b1);
    idle(1'b1); idle(1'b1);
    step(2'b10, 16'h0, 16'h0034, 1'b1);
    chk("s1_flags", 64'(rcv[0]), 64'b11);
    chk("s1_notyet", 64'(jv[0]), 64'd0);
    idle(1'b1);
    chk("s1_valid", 64'(jv[0]), 64'd1);
    chk("s1_data", 64'(jd[0]), 64'h0034_0012);
    idle(1'b1);
    chk("s1_drain", 64'(jv[0]), 64'd0);

    // backpressure and back-to-back replacement
    step(2'b11, 16'h0A01, 16'h0A02, 1'b0);
    idle(1'b0);
    chk("s2_a", 64'(jd[0]), 64'h0A02_0A01);
    step(2'b11, 16'h0B01, 16'h0B02, 1'b0);
    idle(1'b0); idle(1'b0);
    chk("s2_hold", 64'(jd[1]), 64'h0A02_0A01);
    chk("s2_pend", 64'(rcv[1]), 64'b11);
    idle(1'b1);
    chk("s2_b_valid", 64'(jv[0]), 64'd1);
    chk("s2_b", 64'(jd[0]), 64'h0B02_0B01);
    idle(1'b1);
    chk("s2_drain", 64'(jv[0]), 64'd0);

    // repeat valid: keep newest vs keep first
    step(2'b01, 16'h0001, 16'h0, 1'b1);
    step(2'b01, 16'h0002, 16'h0, 1'b1);
    chk("s3_ovr0", 64'(ovc[0]), 64'd1);
    chk("s3_ovr1", 64'(ovc[1]), 64'd1);
    step(2'b10, 16'h0, 16'h0003, 1'b1);
    idle(1'b1);
    chk("s3_newest", 64'(jd[0]), 64'h0003_0002);
    chk("s3_first", 64'(jd[1]), 64'h0003_0001);
    idle(1'b1);

    // valid on the load edge opens the next round
    step(2'b11, 16'h0010, 16'h0020, 1'b1);
    step(2'b01, 16'h00AA, 16'h0, 1'b1);
    chk("s4_frame", 64'(jd[0]), 64'h0020_0010);
    chk("s4_flags", 64'(rcv[0]), 64'b01);
    chk("s4_ovr", 64'(ovc[0]), 64'd1);
    step(2'b10, 16'h0, 16'h00BB, 1'b1);
    chk("s4_gap", 64'(jv[0]), 64'd0);
    idle(1'b1);
    chk("s4_next", 64'(jd[0]), 64'h00BB_00AA);
    idle(1'b1);

    // partial round
    step(2'b10, 16'h0, 16'h0055, 1'b1);
    chk("s5_flags", 64'(rcv[0]), 64'b10);
    if (TO_EN) begin
      repeat (7) idle(1'b1);
      chk("s5_early", 64'(tov[0]), 64'd0);
      chk("s5_early_fl", 64'(rcv[0]), 64'b10);
      idle(1'b1);
      chk("s5_pulse", 64'(tov[0]), 64'd1);
      chk("s5_cleared", 64'(rcv[0]), 64'b00);
      chk("s5_tcnt", 64'(toc[1]), 64'd1);
      idle(1'b1);
      chk("s5_pulse_end", 64'(tov[0]), 64'd0);
    end else begin
      repeat (20) idle(1'b1);
      chk("s5_wait", 64'(rcv[0]), 64'b10);
      chk("s5_notmo", 64'(toc[0]), 64'd0);
      step(2'b01, 16'h0056, 16'h0, 1'b1);
      idle(1'b1);
      chk("s5_done", 64'(jd[0]), 64'h0055_0056);
      idle(1'b1);
    end

    // async reset while a frame is held
    step(2'b11, 16'h0061, 16'h0062, 1'b0);
    idle(1'b0);
    chk("s6_held", 64'(jv[0]), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_rst_valid", 64'(jv[0]), 64'd0);
    chk("s6_rst_flags", 64'(rcv[0]), 64'd0);
    chk("s6_rst_ovr", 64'(ovc[0]), 64'd0);
    chk("s6_rst_data", 64'(jd[1]), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b11, 16'h0071, 16'h0072, 1'b1);
    idle(1'b1);
    chk("s6_fresh", 64'(jd[0]), 64'h0072_0071);
    chk("s6_fresh_v", 64'(jv[1]), 64'd1);
    idle(1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
